// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: one shared counter driving NUM_CH shadowed duty compares with complementary outputs; PWM_DEADTIME_EN adds dead-band.
// Latency: one clk from counter value to pwm_out/pwm_out_n/cnt_wrap; shadowed period/mode/duty go live at the period boundary.
// Backpressure: none; a duty write is accepted every cycle and writes to channels >= NUM_CH are dropped.
module pwm_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int DEAD_W = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period,
    input  logic              mode,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_duty,
    input  logic [DEAD_W-1:0] dead_time,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] pwm_out_n,
    output logic              cnt_wrap
);

    localparam logic [0:0] DIR_UP = 1'b0;
    localparam logic [0:0] DIR_DN = 1'b1;

    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [0:0]                    dir_q, dir_d;
    logic [CNT_W-1:0]              per_act_q, per_act_d;
    logic                          mode_act_q, mode_act_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  duty_sh_q, duty_sh_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  duty_act_q, duty_act_d;
    logic [NUM_CH-1:0]             pwm_q, pwm_d;
    logic [NUM_CH-1:0]             pwm_n_q, pwm_n_d;
    logic                          wrap_q, wrap_d;

    logic [CNT_W-1:0]              per_in;
    logic [CNT_W-1:0]              per_m1;
    logic                          boundary;
    logic                          load;
    logic [NUM_CH-1:0]             raw;

    assign per_in = (period == '0) ? CNT_W'(1) : period;
    assign per_m1 = per_act_q - CNT_W'(1);

    // Edge mode wraps after P-1; center mode wraps once the down ramp reaches 0.
    assign boundary = mode_act_q ? ((dir_q == DIR_DN) && (cnt_q == '0))
                                 : (cnt_q >= per_m1);

    always_comb begin : shadow_c
        duty_sh_d = duty_sh_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                duty_sh_d[i] = cfg_duty;
            end
        end
    end

    always_comb begin : count_c
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        load       = 1'b0;
        per_act_d  = per_act_q;
        mode_act_d = mode_act_q;
        duty_act_d = duty_act_q;
        if (!enable) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            load  = 1'b1;
        end else if (boundary) begin
            cnt_d  = '0;
            dir_d  = DIR_UP;
            wrap_d = 1'b1;
            load   = 1'b1;
        end else if (dir_q == DIR_UP) begin
            // Center mode holds the top value for a second cycle while turning around.
            if (mode_act_q && (cnt_q == per_m1)) begin
                dir_d = DIR_DN;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        // Loading from the write-bypassed shadow lets a boundary-cycle write land in the new period.
        if (load) begin
            per_act_d  = per_in;
            mode_act_d = mode;
            duty_act_d = duty_sh_d;
        end
    end

    always_comb begin : compare_c
        raw = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            raw[i] = (cnt_q < duty_act_q[i]);
        end
    end

`ifdef PWM_DEADTIME_EN
    logic [DEAD_W-1:0]              dead_act_q, dead_act_d;
    logic [NUM_CH-1:0]              last_raw_q, last_raw_d;
    logic [NUM_CH-1:0][DEAD_W-1:0]  run_q, run_d;

    // run_q counts how long raw has held its level; a side may only rise once that reaches dead_act_q.
    always_comb begin : dead_c
        logic [DEAD_W-1:0] run_cur;
        run_cur    = '0;
        dead_act_d = load ? dead_time : dead_act_q;
        last_raw_d = enable ? raw : '0;
        pwm_d      = '0;
        pwm_n_d    = '0;
        run_d      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            run_cur    = (raw[i] != last_raw_q[i]) ? '0 : run_q[i];
            pwm_d[i]   = enable && raw[i] && (run_cur >= dead_act_q);
            pwm_n_d[i] = enable && !raw[i] && (run_cur >= dead_act_q);
            if (enable) begin
                run_d[i] = (run_cur == '1) ? run_cur : run_cur + DEAD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dead_act_q <= '0;
            last_raw_q <= '0;
            run_q      <= '0;
        end else begin
            dead_act_q <= dead_act_d;
            last_raw_q <= last_raw_d;
            run_q      <= run_d;
        end
    end
`else
    logic unused_dead_time;
    assign unused_dead_time = ^dead_time;

    always_comb begin : out_c
        pwm_d   = enable ? raw  : '0;
        pwm_n_d = enable ? ~raw : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            dir_q      <= DIR_UP;
            per_act_q  <= CNT_W'(1);
            mode_act_q <= 1'b0;
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= '0;
            pwm_n_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            per_act_q  <= per_act_d;
            mode_act_q <= mode_act_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
            pwm_n_q    <= pwm_n_d;
            wrap_q     <= wrap_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_out_n = pwm_n_q;
    assign cnt_wrap  = wrap_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel (default build): directed scenarios plus randomized traffic against a period-position reference model.
module tb_pwm_multi_channel;

    localparam int NCH = 5;
    localparam int CW  = 16;
    localparam int DW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [CW-1:0]  period;
    logic           mode;
    logic           cfg_we;
    logic [2:0]     cfg_ch;
    logic [CW-1:0]  cfg_duty;
    logic [DW-1:0]  dead_time;
    logic [NCH-1:0] pwm_out;
    logic [NCH-1:0] pwm_out_n;
    logic           cnt_wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current period plus active/shadow settings.
    int             m_pos;
    int             m_per;
    bit             m_mode;
    int             m_duty[NCH];
    int             m_sh[NCH];
    logic [NCH-1:0] e_out;
    logic [NCH-1:0] e_n;
    logic           e_wrap;

    pwm_multi_channel #(.NUM_CH(NCH), .CNT_W(CW), .DEAD_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .period    (period),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_duty  (cfg_duty),
        .dead_time (dead_time),
        .pwm_out   (pwm_out),
        .pwm_out_n (pwm_out_n),
        .cnt_wrap  (cnt_wrap)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        int p_in;
        int len;
        int c;
        p_in = (period == 0) ? 1 : int'(period);
        if (rst) begin
            m_pos = 0; m_per = 1; m_mode = 0;
            for (int i = 0; i < NCH; i++) begin m_duty[i] = 0; m_sh[i] = 0; end
            e_out = '0; e_n = '0; e_wrap = 1'b0;
        end else begin
            if (cfg_we && int'(cfg_ch) < NCH) m_sh[cfg_ch] = int'(cfg_duty);
            if (!enable) begin
                m_pos = 0; m_per = p_in; m_mode = mode;
                for (int i = 0; i < NCH; i++) m_duty[i] = m_sh[i];
                e_out = '0; e_n = '0; e_wrap = 1'b0;
            end else begin
                len = m_mode ? 2 * m_per : m_per;
                c   = (m_mode && m_pos >= m_per) ? 2 * m_per - 1 - m_pos : m_pos;
                for (int i = 0; i < NCH; i++) begin
                    e_out[i] = (c < m_duty[i]);
                    e_n[i]   = !(c < m_duty[i]);
                end
                if (m_pos == len - 1) begin
                    m_pos = 0; m_per = p_in; m_mode = mode;
                    for (int i = 0; i < NCH; i++) m_duty[i] = m_sh[i];
                    e_wrap = 1'b1;
                end else begin
                    m_pos++;
                    e_wrap = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic wr(input int ch, input int val);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_duty = CW'(val);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; period = 16'd10; mode = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_duty = '0; dead_time = '0;
        tick(); tick();
        if ({pwm_out, pwm_out_n, cnt_wrap} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b/%b/%b want all zero", pwm_out, pwm_out_n, cnt_wrap);
        end
        checks++;
        rst = 1'b0;
        tick();
        if ({pwm_out, pwm_out_n, cnt_wrap} !== '0) begin
            errors++;
            $display("FAIL disabled_outputs got %b/%b/%b want all zero", pwm_out, pwm_out_n, cnt_wrap);
        end
        checks++;
    endtask

    task automatic test_edge();
        int hi[NCH];
        int wraps;
        int want[NCH];
        enable = 1'b0; mode = 1'b0; period = 16'd10; dead_time = 8'd3;
        wr(0, 5); wr(1, 0); wr(2, 10); wr(3, 12); wr(4, 7);
        tick();
        for (int i = 0; i < NCH; i++) hi[i] = 0;
        wraps = 0;
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL edge_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
            for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
            wraps += int'(cnt_wrap);
        end
        want = '{15, 0, 30, 30, 21};
        for (int i = 0; i < NCH; i++) begin
            if (hi[i] != want[i]) begin
                errors++;
                $display("FAIL edge_high_count ch%0d got %0d want %0d", i, hi[i], want[i]);
            end
            checks++;
        end
        if (wraps != 3) begin
            errors++;
            $display("FAIL edge_wrap_count got %0d want 3", wraps);
        end
        checks++;
    endtask

    task automatic test_center();
        int hi0;
        int wraps;
        enable = 1'b0; mode = 1'b1; period = 16'd4;
        wr(0, 1);
        tick();
        hi0 = 0; wraps = 0;
        enable = 1'b1;
        for (int k = 0; k < 32; k++) begin
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL center_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
            hi0 += int'(pwm_out[0]);
            wraps += int'(cnt_wrap);
        end
        if (hi0 != 8 || wraps != 4) begin
            errors++;
            $display("FAIL center_counts got high=%0d wraps=%0d want high=8 wraps=4", hi0, wraps);
        end
        checks++;
    endtask

    task automatic test_shadow_write();
        int hi[3];
        enable = 1'b0; mode = 1'b0; period = 16'd10;
        wr(0, 3);
        tick();
        hi = '{0, 0, 0};
        enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 2)  begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_duty = 16'd7; end
            if (k == 19) begin cfg_we = 1'b1; cfg_ch = 3'd0; cfg_duty = 16'd2; end
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL shadow_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
            hi[k / 10] += int'(pwm_out[0]);
        end
        if (hi[0] != 3 || hi[1] != 7 || hi[2] != 2) begin
            errors++;
            $display("FAIL shadow_high_counts got %0d,%0d,%0d want 3,7,2", hi[0], hi[1], hi[2]);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int hi2;
        // Three writes to ch2 inside one period: only the last one (4) may show in the next period.
        while (m_pos != 0) tick();
        hi2 = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 1) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_duty = 16'd1; end
            if (k == 3) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_duty = 16'd8; end
            if (k == 5) begin cfg_we = 1'b1; cfg_ch = 3'd2; cfg_duty = 16'd4; end
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL b2b_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
            if (k >= 10) hi2 += int'(pwm_out[2]);
        end
        if (hi2 != 4) begin
            errors++;
            $display("FAIL b2b_last_wins got %0d want 4", hi2);
        end
        checks++;
    endtask

    task automatic test_bad_channel();
        int hi1;
        for (int k = 0; k < 25; k++) begin
            if (k < 3) begin cfg_we = 1'b1; cfg_ch = 3'(5 + k); cfg_duty = 16'd9; end
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL badch_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
        end
        enable = 1'b0;
        tick();
        wr(1, 4);
        enable = 1'b1;
        hi1 = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            hi1 += int'(pwm_out[1]);
        end
        if (hi1 != 4) begin
            errors++;
            $display("FAIL disabled_write_ch1 got %0d high cycles want 4", hi1);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 13; k++) tick();
        rst = 1'b1;
        tick();
        if ({pwm_out, pwm_out_n, cnt_wrap} !== '0) begin
            errors++;
            $display("FAIL reset_mid got %b/%b/%b want all zero", pwm_out, pwm_out_n, cnt_wrap);
        end
        checks++;
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (pwm_out !== '0 || {pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL after_reset k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) period = CW'($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            dead_time = DW'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1'b1; cfg_ch = 3'($urandom_range(0, 7)); cfg_duty = CW'($urandom_range(0, 14));
            end
            tick();
            if ({pwm_out, pwm_out_n, cnt_wrap} !== {e_out, e_n, e_wrap}) begin
                errors++;
                $display("FAIL random_model k=%0d got %b/%b/%b want %b/%b/%b", k, pwm_out, pwm_out_n, cnt_wrap, e_out, e_n, e_wrap);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_center();
        test_shadow_write();
        test_back_to_back();
        test_bad_channel();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
Multi-channel PWM generator with one shared counter, a programmable period and NUM_CH independent duty channels.
- Duty and period writes go to shadow registers and become active only at a period boundary, so outputs never glitch.
- Counter runs edge-aligned (sawtooth) or center-aligned (triangle).
- Each channel drives a complementary output pair, intended for motor/LED driver stages.

Parameters:
- NUM_CH, 4, number of PWM channels (>=1)
- CNT_W, 16, width of counter, period and duty values
- DEAD_W, 8, width of dead-time value

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock; reset is synchronous and active-high
- enable  input  1  run counter and outputs
- period  input  CNT_W  period P in clk cycles (edge mode) or half-period (center mode); P=0 is treated as 1; sampled continuously into shadow
- mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled into shadow
- cfg_we  input  1  duty write strobe
- cfg_ch  input  max(1,$clog2(NUM_CH))  channel index for write
- cfg_duty  input  CNT_W  duty value for write
- dead_time  input  DEAD_W  dead-band in cycles (used only with PWM_DEADTIME_EN)
- pwm_out  output  NUM_CH  high-side outputs, registered
- pwm_out_n  output  NUM_CH  low-side (complementary) outputs, registered
- cnt_wrap  output  1  one-cycle pulse at the first cycle of each period

Behaviour:
Reset (rst=1 at a clk edge):
- Counter = 0, direction = up.
- All shadow and active duties = 0; active period = 1; active mode = edge.
- pwm_out = 0, pwm_out_n = 0, cnt_wrap = 0, dead-time counters = 0.
- Reset mid-period aborts the period immediately; pending shadow writes are lost.

Edge mode:
- Counter runs 0,1,…,P-1, then 0. Period length = P cycles.
- Boundary cycle = counter == P-1.

Center mode:
- Counter runs 0,1,…,P-1 up, then P-1,…,0 down; each end value is held for 2 consecutive cycles. Period length = 2P cycles.
- Boundary cycle = direction down and counter == 0.

Boundary cycle:
- Active period, mode and all duties load from the shadows.
- Next cycle the counter = 0, direction = up, and cnt_wrap = 1 for that one cycle.

Compare:
- raw[i] = (counter < duty_act[i]); unsigned, CNT_W bits.
- duty 0 gives constant 0; duty >= P gives constant 1.
- Center mode high time = 2*min(duty,P) cycles, centered on the wrap.
- pwm_out[i] <= raw[i]: 1 cycle latency from counter to output.
- Without the macro, pwm_out_n[i] <= ~raw[i] while enabled.

Duty write:
- cfg_we=1 writes cfg_duty into shadow[cfg_ch].
- cfg_ch >= NUM_CH: write ignored, no state change.
- Write in a boundary cycle takes effect in the new period (bypass to active).
- Multiple writes to the same channel within a period: last write wins.

enable=0:
- Counter held at 0, direction up.
- pwm_out = 0, pwm_out_n = 0, cnt_wrap = 0.
- Shadows copy to active every cycle, so writes take effect immediately.
- On the cycle enable rises, counting starts at 0 with current active values; no cnt_wrap pulse for that first period.

Mode or period change: takes effect only at a boundary. A center/edge switch restarts at 0, direction up.

Optional Feature:
PWM_DEADTIME_EN
- Defined: per channel, a rising edge of either output is delayed by dead_time cycles after the opposite output falls.
  - Falling edges are immediate.
  - pwm_out and pwm_out_n are never both 1.
  - A high phase shorter than dead_time is suppressed entirely.
  - dead_time=0 gives pure complementary behaviour.
  - dead_time is sampled at the boundary together with the other shadows.
- Not defined: dead_time is ignored; pwm_out_n = ~pwm_out while enabled, 0 while disabled; no extra registers are synthesized.

Test Plan:
- Edge, P=10, duty ch0=5, ch1=0, ch2=10, ch3=12, enable → over every 10-cycle period ch0 high 5 cycles (counter 0–4, +1 cycle latency), ch1 always 0, ch2/ch3 always 1; cnt_wrap every 10th cycle.
- Center, P=4, duty ch0=1 → 8-cycle period, counter 0,1,2,3,3,2,1,0; ch0 high when counter=0, giving 2 adjacent cycles across each wrap; cnt_wrap every 8 cycles.
- Edge P=10 running, write ch0 duty 3→7 at counter=2 → current period still 3 high; next period 7 high, starting at the cnt_wrap cycle. A write exactly at the boundary cycle applies to the immediately following period.
- cfg_ch=5 with NUM_CH=4, cfg_we=1 → no channel changes; a disabled-state write to ch1 → active immediately, visible in the first period after enable.
- Assert rst mid-period with duties nonzero → next cycle all outputs 0, counter 0; after release, all duties read as 0 (outputs stay low).
- With PWM_DEADTIME_EN, dead_time=2, edge P=10, duty=5 → pwm_out high 3 cycles, pwm_out_n high 3 cycles, 2-cycle gaps where both are 0; with duty=1 the pwm_out pulse is suppressed.
